// File: rtl/vliw_fetch_queue.sv
// VLIW fetch queue: buffers instruction words plus load data and presents per-lane decode fields.
// Optional stall instrumentation is enabled by defining FETCH_STALL_CNT_EN.
module vliw_fetch_queue #(
    parameter int NLANES = 3,
    parameter int SLOT_W = 20,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NLANES*SLOT_W-1:0]   word,
    input  logic [NLANES*DATA_W-1:0]   data,
    input  logic                       word_valid,
    output logic                       word_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NLANES*4-1:0]        f2dr_inst,
    output logic [NLANES*4-1:0]        f2r_src1,
    output logic [NLANES*4-1:0]        f2r_src2,
    output logic [NLANES*4-1:0]        f2d_dest,
    output logic [NLANES*DATA_W-1:0]   f2d_data
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]                stall_count
`endif
);

    localparam int BUS_W = NLANES * DATA_W;
    localparam int FLD_W = NLANES * 16;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Only the decoded fields are stored; spare slot bits never reach the queue.
    logic [FLD_W-1:0] fields_mem_q [DEPTH];
    logic [BUS_W-1:0] data_mem_q   [DEPTH];
    logic [FLD_W-1:0] fields_d;
    logic [BUS_W-1:0] data_d;
    logic             has_load;
    logic             push;
    logic             pop;
    logic [FLD_W-1:0] head_fields;
    logic             unused_word;

    assign unused_word = ^word;

    assign word_ready = (count_q != CNT_W'(DEPTH));
    assign out_valid  = (count_q != '0);
    assign push       = word_valid & word_ready;
    assign pop        = out_valid & out_ready;

    always_comb begin
        fields_d = '0;
        has_load = 1'b0;
        for (int i = 0; i < NLANES; i++) begin
            fields_d[i*16+12 +: 4] = word[(NLANES-1-i)*SLOT_W+15 +: 4];
            fields_d[i*16+8  +: 4] = word[(NLANES-1-i)*SLOT_W+10 +: 4];
            fields_d[i*16+4  +: 4] = word[(NLANES-1-i)*SLOT_W+5  +: 4];
            fields_d[i*16    +: 4] = word[(NLANES-1-i)*SLOT_W    +: 4];
            if (word[(NLANES-1-i)*SLOT_W+15 +: 4] == 4'b0100) begin
                has_load = 1'b1;
            end
        end
        data_d = has_load ? data : '0;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fields_mem_q[wr_ptr_q] <= fields_d;
            data_mem_q[wr_ptr_q]   <= data_d;
        end
    end

    // An empty queue presents nop/reg0/zero data instead of stale storage.
    always_comb begin
        head_fields = out_valid ? fields_mem_q[rd_ptr_q] : '0;
        f2d_data    = out_valid ? data_mem_q[rd_ptr_q] : '0;
        f2dr_inst   = '0;
        f2r_src1    = '0;
        f2r_src2    = '0;
        f2d_dest    = '0;
        for (int i = 0; i < NLANES; i++) begin
            f2dr_inst[i*4 +: 4] = head_fields[i*16+12 +: 4];
            f2r_src1[i*4 +: 4]  = head_fields[i*16+8  +: 4];
            f2r_src2[i*4 +: 4]  = head_fields[i*16+4  +: 4];
            f2d_dest[i*4 +: 4]  = head_fields[i*16    +: 4];
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where decode refuses a presented word; flush leaves it intact.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    // Default build carries no stall instrumentation.
`endif

endmodule

// File: tb/tb_vliw_fetch_queue.sv
// Table-driven bench for vliw_fetch_queue plus hand-written multi-cycle sequences.
// Stall-counter checks are compiled only when FETCH_STALL_CNT_EN is defined.
module tb_vliw_fetch_queue;

    localparam int NLANES = 3;
    localparam int SLOT_W = 20;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;
    localparam int WORD_W = NLANES * SLOT_W;
    localparam int BUS_W  = NLANES * DATA_W;
    localparam int NVEC   = 28;

    logic              clock;
    logic              reset;
    logic              flush;
    logic [WORD_W-1:0] word;
    logic [BUS_W-1:0]  data;
    logic              word_valid;
    logic              word_ready;
    logic              out_valid;
    logic              out_ready;
    logic [11:0]       f2dr_inst;
    logic [11:0]       f2r_src1;
    logic [11:0]       f2r_src2;
    logic [11:0]       f2d_dest;
    logic [BUS_W-1:0]  f2d_data;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0]       stall_count;
`endif

    vliw_fetch_queue #(
        .NLANES(NLANES),
        .SLOT_W(SLOT_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .word       (word),
        .data       (data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .f2dr_inst  (f2dr_inst),
        .f2r_src1   (f2r_src1),
        .f2r_src2   (f2r_src2),
        .f2d_dest   (f2d_dest),
        .f2d_data   (f2d_data)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [11:0]      ops;
        logic [11:0]      s1;
        logic [11:0]      s2;
        logic [11:0]      dst;
        logic [BUS_W-1:0] data;
    } fields_t;

    typedef struct {
        logic wv;
        logic ordy;
        logic fl;
        int   in_id;
        logic e_ready;
        logic e_valid;
        int   e_id;
    } vec_t;

    fields_t words [5];
    fields_t seq   [12];
    vec_t    vecs  [NVEC];
    fields_t blank;
    int      n_vectors = 0;
    int      n_miscompares = 0;
    int      q [$];

    // Lane 0 occupies the most significant slot; spare slot bits are driven high to prove they are ignored.
    function automatic logic [WORD_W-1:0] build_word(fields_t f);
        logic [WORD_W-1:0] w;
        w = '1;
        for (int i = 0; i < NLANES; i++) begin
            w[(NLANES-1-i)*SLOT_W+15 +: 4] = f.ops[i*4 +: 4];
            w[(NLANES-1-i)*SLOT_W+10 +: 4] = f.s1[i*4 +: 4];
            w[(NLANES-1-i)*SLOT_W+5  +: 4] = f.s2[i*4 +: 4];
            w[(NLANES-1-i)*SLOT_W    +: 4] = f.dst[i*4 +: 4];
        end
        return w;
    endfunction

    function automatic logic [BUS_W-1:0] stored_data(fields_t f);
        for (int i = 0; i < NLANES; i++) begin
            if (f.ops[i*4 +: 4] == 4'h4) return f.data;
        end
        return '0;
    endfunction

    function automatic fields_t mk_seq(int k);
        fields_t f;
        f.ops  = {4'(k+3), ((k % 2) == 0) ? 4'h4 : 4'h9, 4'(k+1)};
        f.s1   = {4'(k), 4'(k+7), 4'(15-k)};
        f.s2   = {4'(2*k), 4'(k+11), 4'(k ^ 5)};
        f.dst  = {4'(k+9), 4'(14-k), 4'(k*3)};
        f.data = {64'(k), 64'h00C0_FFEE_0000_0000, 64'(k*7+1)};
        return f;
    endfunction

    task automatic cmp(string name, logic [BUS_W-1:0] act, logic [BUS_W-1:0] exp);
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(logic wv, logic ordy, logic fl, fields_t f);
        word_valid = wv;
        out_ready  = ordy;
        flush      = fl;
        word       = build_word(f);
        data       = f.data;
    endtask

    task automatic check_output(string tag, logic e_ready, logic e_valid, fields_t f, bit empty);
        fields_t e;
        logic [BUS_W-1:0] e_data;
        e      = empty ? blank : f;
        e_data = empty ? '0 : stored_data(f);
        n_vectors++;
        cmp({tag, " word_ready"}, BUS_W'(word_ready), BUS_W'(e_ready));
        cmp({tag, " out_valid"},  BUS_W'(out_valid),  BUS_W'(e_valid));
        cmp({tag, " f2dr_inst"},  BUS_W'(f2dr_inst),  BUS_W'(e.ops));
        cmp({tag, " f2r_src1"},   BUS_W'(f2r_src1),   BUS_W'(e.s1));
        cmp({tag, " f2r_src2"},   BUS_W'(f2r_src2),   BUS_W'(e.s2));
        cmp({tag, " f2d_dest"},   BUS_W'(f2d_dest),   BUS_W'(e.dst));
        cmp({tag, " f2d_data"},   f2d_data,           e_data);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        blank    = '{12'h0, 12'h0, 12'h0, 12'h0, '0};
        words[0] = '{12'h321, 12'h321, 12'h654, 12'h987, 192'h0DEAD_BEEF};
        words[1] = '{12'h412, 12'hABC, 12'h0F1, 12'h5E7,
                     {64'hA5A5_A5A5_A5A5_A5A5, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210}};
        words[2] = '{12'h512, 12'hABC, 12'h0F1, 12'h5E7,
                     {64'hA5A5_A5A5_A5A5_A5A5, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210}};
        words[3] = '{12'h004, 12'h111, 12'h222, 12'hFFF,
                     {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC}};
        words[4] = '{12'hF0E, 12'h5A5, 12'hA5A, 12'h3C3, 192'h7777};
        for (int k = 0; k < 12; k++) seq[k] = mk_seq(k);

        //             wv    ordy  fl    in  ready valid head
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, -1};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, -1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1,  0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b1,  1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 3, 1'b1, 1'b1,  2};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1,  3};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, -1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, -1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1,  0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1,  0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b1,  0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b1,  0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1,  0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1,  1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1,  2};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1,  3};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, -1};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, -1};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1,  0};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1,  0};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b1,  0};
        vecs[21] = '{1'b1, 1'b0, 1'b1, 4, 1'b0, 1'b1,  0};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, -1};
        vecs[23] = '{1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, -1};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, -1};
        vecs[25] = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, -1};
        vecs[26] = '{1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1,  1};
        vecs[27] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, -1};

        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, blank);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].wv, vecs[i].ordy, vecs[i].fl, words[vecs[i].in_id]);
            #1;
            check_output($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_valid,
                         words[(vecs[i].e_id < 0) ? 0 : vecs[i].e_id], vecs[i].e_id < 0);
            @(negedge clock);
        end

        // Two entries resident, then ten cycles of simultaneous push and pop.
        apply_stimulus(1'b1, 1'b0, 1'b0, seq[0]);
        #1 check_output("pp_fill0", 1'b1, 1'b0, blank, 1'b1);
        @(negedge clock);
        q.push_back(0);
        apply_stimulus(1'b1, 1'b0, 1'b0, seq[1]);
        #1 check_output("pp_fill1", 1'b1, 1'b1, seq[q[0]], 1'b0);
        @(negedge clock);
        q.push_back(1);
        for (int k = 2; k < 12; k++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, seq[k]);
            #1 check_output($sformatf("pp_cycle%0d", k), 1'b1, 1'b1, seq[q[0]], 1'b0);
            @(negedge clock);
            void'(q.pop_front());
            q.push_back(k);
        end
        for (int j = 0; j < 3; j++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, blank);
            #1;
            if (q.size() == 0) check_output($sformatf("pp_drain%0d", j), 1'b1, 1'b0, blank, 1'b1);
            else check_output($sformatf("pp_drain%0d", j), 1'b1, 1'b1, seq[q[0]], 1'b0);
            @(negedge clock);
            if (q.size() != 0) void'(q.pop_front());
        end

`ifdef FETCH_STALL_CNT_EN
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, words[0]);
        @(negedge clock);
        apply_stimulus(1'b0, 1'b0, 1'b0, blank);
        repeat (7) @(negedge clock);
        #1;
        n_vectors++;
        cmp("stall_count_7", BUS_W'(stall_count), BUS_W'(16'd7));
        apply_stimulus(1'b0, 1'b0, 1'b1, blank);
        @(negedge clock);
        apply_stimulus(1'b0, 1'b0, 1'b0, blank);
        #1;
        n_vectors++;
        cmp("stall_after_flush", BUS_W'(stall_count), BUS_W'(16'd8));
        check_output("stall_flush_empty", 1'b1, 1'b0, blank, 1'b1);
        @(negedge clock);
`endif

        // Asynchronous reset asserted between clock edges with a partly filled queue.
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, seq[k]);
            @(negedge clock);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, seq[3]);
        #1 check_output("pre_reset", 1'b1, 1'b1, seq[0], 1'b0);
        #1 reset = 1'b1;
        #1 check_output("async_reset", 1'b1, 1'b0, blank, 1'b1);
`ifdef FETCH_STALL_CNT_EN
        n_vectors++;
        cmp("async_reset stall_count", BUS_W'(stall_count), '0);
`endif
        apply_stimulus(1'b0, 1'b0, 1'b0, blank);
        @(negedge clock);
        reset = 1'b0;
        #1 check_output("post_reset", 1'b1, 1'b0, blank, 1'b1);
        @(negedge clock);
        apply_stimulus(1'b1, 1'b0, 1'b0, seq[5]);
        @(negedge clock);
        apply_stimulus(1'b0, 1'b0, 1'b0, blank);
        #1 check_output("post_reset_push", 1'b1, 1'b1, seq[5], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
